// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the MIPS memory controller: memory-op
// encoding, controller state, and store lane/alignment rules.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd7,
    SH  = 4'd8,
    SW  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one;
  // byte ops and the unaligned LWL/LWR pair never fault.
  function automatic logic misaligned(input mem_op_t op, input logic [1:0] k);
    case (op)
      LH, LHU, SH: return k[0];
      LW, SW:      return k != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Loads always read the full word.
  function automatic logic [3:0] store_be(input mem_op_t op, input logic [1:0] k);
    case (op)
      SB:      return 4'b0001 << k;
      SH:      return k[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate the data on every lane; byteenable picks the lane.
  function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] rt);
    case (op)
      SB:      return {4{rt[7:0]}};
      SH:      return {2{rt[15:0]}};
      SW:      return rt;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load formatting: extracts and extends the addressed byte/halfword from a
// little-endian bus word, and merges partial words for LWL/LWR.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] readdata,
  input  logic [31:0] rtdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend or merge according to the op.
  always_comb begin
    byte_sel = readdata[{k, 3'b000} +: 8];
    half_sel = k[1] ? readdata[31:16] : readdata[15:0];
    result   = readdata;
    case (op)
      LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LBU: result = {24'h000000, byte_sel};
      LH:  result = {{16{half_sel[15]}}, half_sel};
      LHU: result = {16'h0000, half_sel};
      LWL: begin
        case (k)
          2'd0:    result = {readdata[7:0],  rtdata[23:0]};
          2'd1:    result = {readdata[15:0], rtdata[15:0]};
          2'd2:    result = {readdata[23:0], rtdata[7:0]};
          default: result = readdata;
        endcase
      end
      LWR: begin
        case (k)
          2'd1:    result = {rtdata[31:24], readdata[31:8]};
          2'd2:    result = {rtdata[31:16], readdata[31:16]};
          2'd3:    result = {rtdata[31:8],  readdata[31:24]};
          default: result = readdata;
        endcase
      end
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_memctrl.sv
// MIPS load/store unit front end: accepts one memory request at a time,
// runs a single Avalon-MM word access, and reports a formatted result.
module mips_cpu_memctrl
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  mem_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rtdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_t      state, state_d;
  mem_op_t     op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] rt_q, rt_d;

  logic [31:0] address_d, writedata_d, rdata_d;
  logic        read_d, write_d, fault_d;
  logic [3:0]  byteenable_d;
  logic [31:0] load_result;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mips_cpu_load_align u_load_align (
    .op       (op_q),
    .k        (k_q),
    .readdata (readdata),
    .rtdata   (rt_q),
    .result   (load_result)
  );

  // Next-state and next bus/result values; everything holds unless changed.
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    k_d          = k_q;
    rt_d         = rt_q;
    address_d    = address;
    read_d       = read;
    write_d      = write;
    writedata_d  = writedata;
    byteenable_d = byteenable;
    rdata_d      = rdata;
    fault_d      = fault;

    case (state)
      IDLE: begin
        if (req) begin
          op_d = req_op;
          k_d  = req_addr[1:0];
          rt_d = req_rtdata;
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d      = ACCESS;
            address_d    = {req_addr[31:2], 2'b00};
            read_d       = !is_store(req_op);
            write_d      = is_store(req_op);
            byteenable_d = store_be(req_op, req_addr[1:0]);
            writedata_d  = store_data(req_op, req_rtdata);
          end
        end
      end
      ACCESS: begin
        // Bus outputs stay frozen while the slave stalls.
        if (!waitrequest) begin
          state_d      = DONE;
          address_d    = '0;
          read_d       = 1'b0;
          write_d      = 1'b0;
          writedata_d  = '0;
          byteenable_d = '0;
          fault_d      = 1'b0;
          rdata_d      = is_store(op_q) ? '0 : load_result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs; reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= LB;
      k_q        <= '0;
      rt_q       <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rdata      <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      k_q        <= k_d;
      rt_q       <= rt_d;
      address    <= address_d;
      read       <= read_d;
      write      <= write_d;
      writedata  <= writedata_d;
      byteenable <= byteenable_d;
      rdata      <= rdata_d;
      fault      <= fault_d;
    end
  end

endmodule
